// File: rtl/boa_csr_mfile_if.sv
// rtl/boa_csr_mfile_if.sv - CSR access bus and CSR exception event bus for the Boa32 core
interface boa_csr_bus;
  logic        we;
  logic [11:0] addr;
  logic [31:0] wdata;
  logic        exists;
  logic        rdonly;
  logic [1:0]  priv;
  logic [31:0] rdata;

  modport CSR (input we, addr, wdata, output exists, rdonly, priv, rdata);
  modport CPU (output we, addr, wdata, input exists, rdonly, priv, rdata);
endinterface

interface boa_csr_ex_bus;
  logic        ex_trap;
  logic        ex_irq;
  logic [4:0]  ex_cause;
  logic [30:0] ex_epc;
  logic [1:0]  ex_pp;
  logic [1:0]  ex_priv;
  logic [29:0] ex_tvec;
  logic        ret;
  logic        ret_priv;
  logic [1:0]  ret_pp;
  logic [30:0] ret_epc;
  logic [31:0] irq_ip;
  logic [31:0] irq_mie;
  logic [31:0] irq_mideleg;
  logic [31:0] irq_medeleg;
  logic [31:0] irq_sie;

  modport CSR (input ex_trap, ex_irq, ex_cause, ex_epc, ex_pp, ex_priv, ret, ret_priv, irq_ip,
               output ex_tvec, ret_pp, ret_epc, irq_mie, irq_mideleg, irq_medeleg, irq_sie);
  modport CPU (output ex_trap, ex_irq, ex_cause, ex_epc, ex_pp, ex_priv, ret, ret_priv, irq_ip,
               input ex_tvec, ret_pp, ret_epc, irq_mie, irq_mideleg, irq_medeleg, irq_sie);
endinterface

// File: rtl/boa_csr_mfile.sv
// rtl/boa_csr_mfile.sv - Boa32 machine-mode CSR file: trap state, mie/mscratch, cycle/instret counters
module boa_csr_mfile #(
  parameter logic [31:0] MHARTID    = 32'h0,
  parameter logic [31:0] MVENDORID  = 32'h0,
  parameter logic [31:0] MARCHID    = 32'h0,
  parameter logic [31:0] MIMPID     = 32'h0,
  parameter logic [31:0] MISA       = 32'h4000_1100,
  parameter logic [31:0] RESET_TVEC = 32'h0
) (
  input logic         clk,
  input logic         rst_n,
  boa_csr_bus.CSR     csr,
  boa_csr_ex_bus.CSR  ex,
  input logic         retire
);

  logic        st_mie;
  logic        st_mpie;
  logic [1:0]  st_mpp;
  logic [31:0] mie_q;
  logic [31:0] mscratch_q;
  logic [29:0] tvec_base;
  logic [1:0]  tvec_mode;
  logic [30:0] mepc_q;
  logic        cause_irq;
  logic [4:0]  cause_code;
  logic [63:0] mcycle_q;
  logic [63:0] minstret_q;

  logic [31:0] mstatus_rd;
  logic [31:0] rdata;
  logic        exists;
  logic        rdonly;
  logic        trap;
  logic        do_ret;
  logic        wr;
  logic        wr_cyc_lo;
  logic        wr_cyc_hi;
  logic        wr_ins_lo;
  logic        wr_ins_hi;
  logic [1:0]  unused_priv;

  assign unused_priv = ex.ex_priv;
  assign mstatus_rd  = {19'b0, st_mpp, 3'b0, st_mpie, 3'b0, st_mie, 3'b0};

  always_comb begin
    exists = 1'b1;
    rdata  = 32'h0;
    case (csr.addr)
      12'h300:          rdata = mstatus_rd;
      12'h301:          rdata = MISA;
      12'h302, 12'h303,
      12'h343:          rdata = 32'h0;
      12'h304:          rdata = mie_q;
      12'h305:          rdata = {tvec_base, tvec_mode};
      12'h340:          rdata = mscratch_q;
      12'h341:          rdata = {mepc_q, 1'b0};
      12'h342:          rdata = {cause_irq, 26'b0, cause_code};
      12'h344:          rdata = ex.irq_ip;
      12'hB00, 12'hC00: rdata = mcycle_q[31:0];
      12'hB80, 12'hC80: rdata = mcycle_q[63:32];
      12'hB02, 12'hC02: rdata = minstret_q[31:0];
      12'hB82, 12'hC82: rdata = minstret_q[63:32];
      12'hF11:          rdata = MVENDORID;
      12'hF12:          rdata = MARCHID;
      12'hF13:          rdata = MIMPID;
      12'hF14:          rdata = MHARTID;
      default:          exists = 1'b0;
    endcase
  end

  assign rdonly     = (csr.addr[11:10] == 2'b11);
  assign csr.exists = exists;
  assign csr.rdata  = rdata;
  assign csr.rdonly = rdonly;
  assign csr.priv   = csr.addr[9:8];

  // A trap outranks a return, and either one drops the CSR write of that cycle.
  assign trap   = ex.ex_trap | ex.ex_irq;
  assign do_ret = ex.ret & ex.ret_priv & ~trap;
  assign wr     = csr.we & exists & ~rdonly & ~trap & ~do_ret;

  assign wr_cyc_lo = wr && (csr.addr == 12'hB00);
  assign wr_cyc_hi = wr && (csr.addr == 12'hB80);
  assign wr_ins_lo = wr && (csr.addr == 12'hB02);
  assign wr_ins_hi = wr && (csr.addr == 12'hB82);

  assign ex.ex_tvec     = (tvec_mode == 2'b01 && ex.ex_irq) ? tvec_base + {25'b0, ex.ex_cause}
                                                            : tvec_base;
  assign ex.ret_pp      = st_mpp;
  assign ex.ret_epc     = mepc_q;
  assign ex.irq_mie     = mie_q;
  assign ex.irq_mideleg = 32'h0;
  assign ex.irq_medeleg = 32'h0;
  assign ex.irq_sie     = ex.irq_ip & mie_q & {32{st_mie}};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_mie     <= 1'b0;
      st_mpie    <= 1'b0;
      st_mpp     <= 2'b11;
      mie_q      <= 32'h0;
      mscratch_q <= 32'h0;
      tvec_base  <= RESET_TVEC[31:2];
      tvec_mode  <= RESET_TVEC[1:0];
      mepc_q     <= 31'h0;
      cause_irq  <= 1'b0;
      cause_code <= 5'h0;
      mcycle_q   <= 64'h0;
      minstret_q <= 64'h0;
    end else begin
      if (trap) begin
        mepc_q     <= ex.ex_epc;
        cause_irq  <= ex.ex_irq;
        cause_code <= ex.ex_cause;
        st_mpie    <= st_mie;
        st_mie     <= 1'b0;
        st_mpp     <= ex.ex_pp;
      end else if (do_ret) begin
        st_mie  <= st_mpie;
        st_mpie <= 1'b1;
        st_mpp  <= 2'b00;
      end else if (wr) begin
        case (csr.addr)
          12'h300: begin
            st_mie  <= csr.wdata[3];
            st_mpie <= csr.wdata[7];
            // MPP only holds M or U; anything else leaves it alone.
            if (csr.wdata[12:11] == 2'b00 || csr.wdata[12:11] == 2'b11)
              st_mpp <= csr.wdata[12:11];
          end
          12'h304: mie_q      <= csr.wdata;
          12'h305: begin
            tvec_base <= csr.wdata[31:2];
            if (!csr.wdata[1])
              tvec_mode <= csr.wdata[1:0];
          end
          12'h340: mscratch_q <= csr.wdata;
          12'h341: mepc_q     <= csr.wdata[31:1];
          12'h342: begin
            cause_irq  <= csr.wdata[31];
            cause_code <= csr.wdata[4:0];
          end
          default: ;
        endcase
      end

      if (wr_cyc_lo)      mcycle_q <= {mcycle_q[63:32], csr.wdata};
      else if (wr_cyc_hi) mcycle_q <= {csr.wdata, mcycle_q[31:0]};
      else                mcycle_q <= mcycle_q + 64'd1;

      if (wr_ins_lo)      minstret_q <= {minstret_q[63:32], csr.wdata};
      else if (wr_ins_hi) minstret_q <= {csr.wdata, minstret_q[31:0]};
      else                minstret_q <= minstret_q + {63'b0, retire};
    end
  end

endmodule

// File: tb/tb_boa_csr_mfile.sv
// tb/tb_boa_csr_mfile.sv - randomized self-checking bench for boa_csr_mfile against a register-level model
module tb_boa_csr_mfile;
  localparam logic [31:0] HART  = 32'h0000_00A5;
  localparam logic [31:0] VEND  = 32'h1234_5678;
  localparam logic [31:0] ARCH  = 32'h0000_0042;
  localparam logic [31:0] IMP   = 32'h0000_0007;
  localparam logic [31:0] ISA   = 32'h4000_1100;
  localparam logic [31:0] RTVEC = 32'h0000_0201;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic retire = 1'b0;
  always #5 clk = ~clk;

  boa_csr_bus    csr_if ();
  boa_csr_ex_bus ex_if ();

  boa_csr_mfile #(
    .MHARTID(HART), .MVENDORID(VEND), .MARCHID(ARCH), .MIMPID(IMP),
    .MISA(ISA), .RESET_TVEC(RTVEC)
  ) dut (
    .clk(clk), .rst_n(rst_n), .csr(csr_if), .ex(ex_if), .retire(retire)
  );

  int n_cmp = 0;
  int n_mis = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference state kept as whole architectural register values.
  logic [31:0] m_mstatus, m_mtvec, m_mie, m_mscratch, m_mepc, m_mcause;
  logic [63:0] m_cyc, m_ins;

  task automatic model_reset();
    m_mstatus = 32'h0000_1800; m_mtvec = RTVEC; m_mie = 0; m_mscratch = 0;
    m_mepc = 0; m_mcause = 0; m_cyc = 0; m_ins = 0;
  endtask

  function automatic logic [32:0] model_read(input logic [11:0] a);
    case (a)
      12'h300: return {1'b1, m_mstatus};
      12'h301: return {1'b1, ISA};
      12'h302, 12'h303, 12'h343: return {1'b1, 32'h0};
      12'h304: return {1'b1, m_mie};
      12'h305: return {1'b1, m_mtvec};
      12'h340: return {1'b1, m_mscratch};
      12'h341: return {1'b1, m_mepc};
      12'h342: return {1'b1, m_mcause};
      12'h344: return {1'b1, ex_if.irq_ip};
      12'hB00, 12'hC00: return {1'b1, m_cyc[31:0]};
      12'hB80, 12'hC80: return {1'b1, m_cyc[63:32]};
      12'hB02, 12'hC02: return {1'b1, m_ins[31:0]};
      12'hB82, 12'hC82: return {1'b1, m_ins[63:32]};
      12'hF11: return {1'b1, VEND};
      12'hF12: return {1'b1, ARCH};
      12'hF13: return {1'b1, IMP};
      12'hF14: return {1'b1, HART};
      default: return 33'h0;
    endcase
  endfunction

  task automatic idle();
    csr_if.we = 0; csr_if.addr = 12'h7C0; csr_if.wdata = 0;
    ex_if.ex_trap = 0; ex_if.ex_irq = 0; ex_if.ex_cause = 0; ex_if.ex_epc = 0;
    ex_if.ex_pp = 0; ex_if.ex_priv = 0; ex_if.ret = 0; ex_if.ret_priv = 0;
    retire = 0;
  endtask

  // Mid-cycle: compare every combinational output with the model.
  task automatic settle();
    logic [32:0] r;
    logic [29:0] tv;
    #3;
    r = model_read(csr_if.addr);
    tv = m_mtvec[31:2];
    if (m_mtvec[1:0] == 2'b01 && ex_if.ex_irq) tv = tv + 30'(ex_if.ex_cause);
    check("exists", csr_if.exists, r[32]);
    check("rdata", csr_if.rdata, r[31:0]);
    check("rdonly", csr_if.rdonly, csr_if.addr[11:10] == 2'b11);
    check("priv", csr_if.priv, csr_if.addr[9:8]);
    check("ex_tvec", ex_if.ex_tvec, tv);
    check("ret_pp", ex_if.ret_pp, m_mstatus[12:11]);
    check("ret_epc", ex_if.ret_epc, m_mepc[31:1]);
    check("irq_mie", ex_if.irq_mie, m_mie);
    check("irq_deleg", {ex_if.irq_mideleg, ex_if.irq_medeleg}, 64'h0);
    check("irq_sie", ex_if.irq_sie, m_mstatus[3] ? (ex_if.irq_ip & m_mie) : 32'h0);
  endtask

  // Clock edge: apply trap > ret > write rules to the model.
  task automatic tick();
    logic trap, retv, wr;
    logic [11:0] a;
    logic [31:0] w;
    logic [63:0] nc, ni;
    @(posedge clk);
    a = csr_if.addr; w = csr_if.wdata;
    trap = ex_if.ex_trap || ex_if.ex_irq;
    retv = ex_if.ret && ex_if.ret_priv && !trap;
    wr = csr_if.we && model_read(a)[32] && (a[11:10] != 2'b11) && !trap && !retv;
    nc = m_cyc + 1;
    ni = m_ins + (retire ? 64'd1 : 64'd0);
    if (wr) begin
      case (a)
        12'h300: m_mstatus = (w & 32'h88) |
                 ((w[12:11] == 2'b00 || w[12:11] == 2'b11) ? (w & 32'h1800) : (m_mstatus & 32'h1800));
        12'h304: m_mie = w;
        12'h305: m_mtvec = {w[31:2], (w[1:0] <= 2'b01) ? w[1:0] : m_mtvec[1:0]};
        12'h340: m_mscratch = w;
        12'h341: m_mepc = w & ~32'h1;
        12'h342: m_mcause = w & 32'h8000_001F;
        12'hB00: nc = {m_cyc[63:32], w};
        12'hB80: nc = {w, m_cyc[31:0]};
        12'hB02: ni = {m_ins[63:32], w};
        12'hB82: ni = {w, m_ins[31:0]};
        default: ;
      endcase
    end
    if (trap) begin
      m_mepc = {ex_if.ex_epc, 1'b0};
      m_mcause = {ex_if.ex_irq, 26'b0, ex_if.ex_cause};
      m_mstatus = {19'b0, ex_if.ex_pp, 3'b0, m_mstatus[3], 7'b0};
    end else if (retv) begin
      m_mstatus = {19'b0, 2'b00, 3'b0, 1'b1, 3'b0, m_mstatus[7], 3'b0};
    end
    m_cyc = nc; m_ins = ni;
    #1;
  endtask

  task automatic step();
    settle();
    tick();
  endtask

  task automatic wr(input logic [11:0] a, input logic [31:0] d);
    idle(); csr_if.we = 1; csr_if.addr = a; csr_if.wdata = d;
    step();
  endtask

  task automatic rd(input string tag, input logic [11:0] a, input logic [31:0] exp);
    idle(); csr_if.addr = a;
    settle();
    check(tag, csr_if.rdata, exp);
    tick();
  endtask

  logic [11:0] addrs [25] = '{12'h300, 12'h301, 12'h302, 12'h303, 12'h304, 12'h305, 12'h340,
                              12'h341, 12'h342, 12'h343, 12'h344, 12'hB00, 12'hB80, 12'hB02,
                              12'hB82, 12'hC00, 12'hC80, 12'hC02, 12'hC82, 12'hF11, 12'hF12,
                              12'hF13, 12'hF14, 12'h7C0, 12'h123};

  initial begin
    model_reset();
    idle();
    ex_if.irq_ip = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1;

    rd("reset_mstatus", 12'h300, 32'h0000_1800);
    rd("mhartid", 12'hF14, HART);
    rd("reset_mtvec", 12'h305, RTVEC);
    idle(); csr_if.addr = 12'h7C0; settle();
    check("unmapped_exists", csr_if.exists, 1'b0);
    check("unmapped_rdata", csr_if.rdata, 32'h0);
    tick();
    idle(); csr_if.addr = 12'hC00; settle();
    check("c00_rdonly", csr_if.rdonly, 1'b1);
    check("c00_priv", csr_if.priv, 2'b00);
    tick();

    wr(12'h305, 32'h8000_0101);
    rd("mtvec_rb", 12'h305, 32'h8000_0101);
    idle(); ex_if.ex_irq = 1; ex_if.ex_cause = 5'd7; settle();
    check("tvec_vectored", {ex_if.ex_tvec, 2'b00}, 32'h8000_011C);
    tick();
    idle(); ex_if.ex_trap = 1; ex_if.ex_cause = 5'd2; settle();
    check("tvec_exc", {ex_if.ex_tvec, 2'b00}, 32'h8000_0100);
    tick();

    wr(12'h300, 32'h8);
    idle(); ex_if.ex_trap = 1; ex_if.ex_epc = 31'(32'h1234 >> 1); ex_if.ex_cause = 5'd2;
    step();
    rd("trap_mstatus", 12'h300, 32'h80);
    rd("trap_mepc", 12'h341, 32'h1234);
    rd("trap_mcause", 12'h342, 32'h2);
    idle(); ex_if.ret = 1; ex_if.ret_priv = 1; settle();
    check("ret_epc", {ex_if.ret_epc, 1'b0}, 32'h1234);
    tick();
    rd("ret_mstatus", 12'h300, 32'h88);

    wr(12'hB00, 32'hFFFF_FFFE);
    idle(); step();
    idle(); step();
    rd("cycle_wrap_lo", 12'hC00, 32'h0);
    rd("cycle_wrap_hi", 12'hC80, 32'h1);
    wr(12'hC00, 32'h1234_5678);
    rd("c00_ro_write", 12'hC00, m_cyc[31:0]);

    idle(); csr_if.we = 1; csr_if.addr = 12'h340; csr_if.wdata = 32'h55; ex_if.ex_trap = 1;
    step();
    rd("trap_drops_write", 12'h340, 32'h0);
    wr(12'h300, 32'h1800);
    wr(12'h300, 32'h0800);
    rd("mpp_warl", 12'h300, 32'h1800);

    wr(12'h304, 32'h80);
    wr(12'h300, 32'h8);
    ex_if.irq_ip = 32'h880;
    idle(); csr_if.addr = 12'h344; settle();
    check("irq_sie_on", ex_if.irq_sie, 32'h80);
    check("mip_read", csr_if.rdata, 32'h880);
    tick();
    wr(12'h300, 32'h0);
    idle(); settle();
    check("irq_sie_off", ex_if.irq_sie, 32'h0);
    tick();

    for (int i = 0; i < 600; i++) begin
      idle();
      csr_if.we = $urandom_range(0, 1) == 1;
      csr_if.addr = addrs[$urandom_range(0, 24)];
      csr_if.wdata = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF - $urandom_range(0, 3) : $urandom;
      ex_if.ex_trap = $urandom_range(0, 9) == 0;
      ex_if.ex_irq = $urandom_range(0, 11) == 0;
      ex_if.ex_cause = 5'($urandom);
      ex_if.ex_epc = 31'($urandom);
      ex_if.ex_pp = 2'($urandom);
      ex_if.ex_priv = 2'($urandom);
      ex_if.ret = $urandom_range(0, 7) == 0;
      ex_if.ret_priv = $urandom_range(0, 1) == 1;
      retire = $urandom_range(0, 1) == 1;
      if ($urandom_range(0, 7) == 0) ex_if.irq_ip = $urandom;
      if (i == 300) begin
        csr_if.we = 1; csr_if.addr = 12'h340; csr_if.wdata = 32'hDEAD_BEEF;
        ex_if.ex_trap = 0; ex_if.ex_irq = 0; ex_if.ret = 0;
        #2 rst_n = 0;
        #1;
        model_reset();
        check("async_reset_mscratch", csr_if.rdata, 32'h0);
        @(posedge clk);
        #1 rst_n = 1;
        rd("post_reset_mscratch", 12'h340, 32'h0);
      end else begin
        step();
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
